// File: rtl/led_pattern_driver.sv
// led_pattern_driver
//   Multi-channel status-LED driver. A shared prescaler produces a one-clock
//   tick strobe every DIV = CLK_HZ/TICK_HZ clocks. Each channel independently
//   runs OFF, ON, BLINK (50% duty, half-period = period ticks) or BURST
//   (burst_cnt pulses of period ticks on/off, then a gap of 4*period ticks).
//   Channels share only the prescaler and the period/burst_cnt inputs.
module led_pattern_driver #(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [CNT_W-1:0]    period,
  input  logic [3:0]          burst_cnt,
  output logic [NUM_CH-1:0]   led_out,
  output logic                tick_out
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_BURST = 2'b11
  } mode_e;

  // B_ON is encoded as zero so that a cleared channel sits in it.
  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } burst_e;

  if (DIV < 2) begin : g_div_check
    $error("led_pattern_driver: CLK_HZ/TICK_HZ must be at least 2");
  end

  // Shared timing terms. period==0 behaves like period==1; it is used live,
  // so a shrinking period ends the current phase on the next tick.
  logic [CNT_W-1:0] eff_p;
  logic [CNT_W-1:0] eff_p_m1;
  logic [CNT_W+1:0] gap_last;

  assign eff_p    = (period == '0) ? CNT_W'(1) : period;
  assign eff_p_m1 = eff_p - CNT_W'(1);
  assign gap_last = {eff_p, 2'b00} - (CNT_W+2)'(1);

  logic [PS_W-1:0] ps_cnt;
  logic            ps_wrap;

  assign ps_wrap = (ps_cnt == PS_W'(DIV - 1));

  // Prescaler: count 0..DIV-1, strobe tick_out for the clock after the wrap.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt   <= '0;
      tick_out <= 1'b0;
    end else begin
      ps_cnt   <= ps_wrap ? '0 : ps_cnt + PS_W'(1);
      tick_out <= ps_wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e            ch_mode;
    mode_e            prev_q;
    burst_e           st_q;
    burst_e           st_nxt;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_nxt;
    logic [CNT_W+1:0] gap_q;
    logic [CNT_W+1:0] gap_nxt;
    logic [3:0]       pulses_q;
    logic [3:0]       pulses_nxt;
    logic             led_q;
    logic             led_nxt;
    logic             mode_chg;
    logic             ph_term;
    logic             gap_term;
    logic             burst_none;

    assign ch_mode    = mode_e'(mode[2*i +: 2]);
    assign mode_chg   = (ch_mode != prev_q);
    assign ph_term    = (phase_q >= eff_p_m1);
    assign gap_term   = (gap_q >= gap_last);
    assign burst_none = (burst_cnt == 4'd0);
    assign led_out[i] = led_q;

    // State register: remembered mode, burst state, counters and LED drive.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q   <= M_OFF;
        st_q     <= B_ON;
        phase_q  <= '0;
        gap_q    <= '0;
        pulses_q <= '0;
        led_q    <= 1'b0;
      end else begin
        prev_q   <= ch_mode;
        st_q     <= st_nxt;
        phase_q  <= phase_nxt;
        gap_q    <= gap_nxt;
        pulses_q <= pulses_nxt;
        led_q    <= led_nxt;
      end
    end

    // Next state: a mode change restarts the channel and masks any tick.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
      st_nxt     = st_q;
      phase_nxt  = phase_q;
      gap_nxt    = gap_q;
      pulses_nxt = pulses_q;
      if (mode_chg) begin
        phase_nxt  = '0;
        gap_nxt    = '0;
        pulses_nxt = '0;
        st_nxt     = (ch_mode == M_BURST && burst_none) ? B_GAP : B_ON;
      end else begin
        case (ch_mode)
          M_BLINK: begin
            gap_nxt    = '0;
            pulses_nxt = '0;
            st_nxt     = B_ON;
            if (tick_out) phase_nxt = ph_term ? '0 : phase_q + CNT_W'(1);
          end
          M_BURST: begin
            if (tick_out) begin
              case (st_q)
                B_ON: begin
                  if (ph_term) begin
                    st_nxt     = B_OFF;
                    phase_nxt  = '0;
                    pulses_nxt = pulses_q + 4'd1;
                  end else begin
                    phase_nxt = phase_q + CNT_W'(1);
                  end
                end
                B_OFF: begin
                  if (ph_term) begin
                    phase_nxt = '0;
                    if (pulses_q >= burst_cnt) begin
                      st_nxt     = B_GAP;
                      pulses_nxt = '0;
                      gap_nxt    = '0;
                    end else begin
                      st_nxt = B_ON;
                    end
                  end else begin
                    phase_nxt = phase_q + CNT_W'(1);
                  end
                end
                B_GAP: begin
                  if (gap_term) begin
                    gap_nxt = '0;
                    st_nxt  = burst_none ? B_GAP : B_ON;
                  end else begin
                    gap_nxt = gap_q + (CNT_W+2)'(1);
                  end
                end
                default: st_nxt = B_ON;
              endcase
            end
          end
          default: begin
            phase_nxt  = '0;
            gap_nxt    = '0;
            pulses_nxt = '0;
            st_nxt     = B_ON;
          end
        endcase
      end
    end

    // Output: LED value the channel drives after this clock.
    always_comb begin
      led_nxt = led_q;
      case (ch_mode)
        M_OFF:   led_nxt = 1'b0;
        M_ON:    led_nxt = 1'b1;
        M_BLINK: begin
          if (mode_chg)                 led_nxt = 1'b0;
          else if (tick_out && ph_term) led_nxt = ~led_q;
        end
        M_BURST: led_nxt = (st_nxt == B_ON);
        default: led_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver
//   Table-driven and hand-written checks plus randomized segments compared
//   against a tick-count model: each channel's LED is a function of the
//   number of ticks seen since it entered its mode.
module tb_led_pattern_driver;

  localparam int NUM_CH  = 4;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int CNT_W   = 16;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NV      = 21;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*NUM_CH-1:0] mode;
  logic [CNT_W-1:0]    period;
  logic [3:0]          burst_cnt;
  logic [NUM_CH-1:0]   led_out;
  logic                tick_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int                m_cyc = 0;
  logic              m_tick = 1'b0;
  logic [1:0]        m_mode [NUM_CH];
  int                m_k    [NUM_CH];
  logic [NUM_CH-1:0] m_led = '0;

  typedef struct packed {
    logic [7:0]  mode;
    logic [15:0] period;
    logic [3:0]  bcnt;
    logic [7:0]  ticks;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs [NV];

  led_pattern_driver #(
    .NUM_CH  (NUM_CH),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .period    (period),
    .burst_cnt (burst_cnt),
    .led_out   (led_out),
    .tick_out  (tick_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // LED after k ticks in a mode: BLINK toggles every p ticks starting low;
  // BURST repeats n on/off pairs of p ticks each followed by 4p dark ticks.
  function automatic logic led_fn(input logic [1:0] md, input int k, input int p_raw, input int n);
    int p;
    int pos;
    p = (p_raw == 0) ? 1 : p_raw;
    case (md)
      2'b00: return 1'b0;
      2'b01: return 1'b1;
      2'b10: return ((k / p) % 2) == 1;
      default: begin
        if (n == 0) return 1'b0;
        pos = k % (2*n*p + 4*p);
        return (pos < 2*n*p) && (((pos / p) % 2) == 0);
      end
    endcase
  endfunction

  task automatic model_step();
    logic tick_in;
    if (rst) begin
      m_cyc  = 0;
      m_tick = 1'b0;
      m_led  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = 2'b00;
        m_k[i]    = 0;
      end
    end else begin
      tick_in = m_tick;
      m_cyc++;
      m_tick = ((m_cyc % DIV) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if (mode[2*i +: 2] != m_mode[i]) begin
          m_mode[i] = mode[2*i +: 2];
          m_k[i]    = 0;
        end else if (tick_in) begin
          m_k[i]++;
        end
        m_led[i] = led_fn(m_mode[i], m_k[i], int'(period), int'(burst_cnt));
      end
    end
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic tick_clk();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic do_reset(input logic [7:0] m, input logic [15:0] p, input logic [3:0] b);
    rst       = 1'b1;
    mode      = m;
    period    = p;
    burst_cnt = b;
    tick_clk();
    rst = 1'b0;
  endtask

  initial begin
    logic seen;
    logic lit;
    int   len;
    int   ch;

    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 2'b00;
      m_k[i]    = 0;
    end

    // k-tick vectors: ch0 BLINK, ch1 BURST, ch2 ON, ch3 OFF unless mode=FF.
    vecs[0]  = '{8'h1E, 16'd1, 4'd2, 8'd0,  4'b0110};
    vecs[1]  = '{8'h1E, 16'd1, 4'd2, 8'd1,  4'b0101};
    vecs[2]  = '{8'h1E, 16'd1, 4'd2, 8'd2,  4'b0110};
    vecs[3]  = '{8'h1E, 16'd1, 4'd2, 8'd3,  4'b0101};
    vecs[4]  = '{8'h1E, 16'd1, 4'd2, 8'd4,  4'b0100};
    vecs[5]  = '{8'h1E, 16'd1, 4'd2, 8'd7,  4'b0101};
    vecs[6]  = '{8'h1E, 16'd1, 4'd2, 8'd8,  4'b0110};
    vecs[7]  = '{8'h1E, 16'd3, 4'd2, 8'd2,  4'b0110};
    vecs[8]  = '{8'h1E, 16'd3, 4'd2, 8'd3,  4'b0101};
    vecs[9]  = '{8'h1E, 16'd3, 4'd2, 8'd6,  4'b0110};
    vecs[10] = '{8'h1E, 16'd3, 4'd2, 8'd12, 4'b0100};
    vecs[11] = '{8'h1E, 16'd3, 4'd2, 8'd23, 4'b0101};
    vecs[12] = '{8'h1E, 16'd3, 4'd2, 8'd24, 4'b0110};
    vecs[13] = '{8'h1E, 16'd0, 4'd0, 8'd0,  4'b0100};
    vecs[14] = '{8'h1E, 16'd0, 4'd0, 8'd1,  4'b0101};
    vecs[15] = '{8'h1E, 16'd0, 4'd0, 8'd2,  4'b0100};
    vecs[16] = '{8'h1E, 16'd0, 4'd0, 8'd5,  4'b0101};
    vecs[17] = '{8'hFF, 16'd2, 4'd1, 8'd0,  4'b1111};
    vecs[18] = '{8'hFF, 16'd2, 4'd1, 8'd2,  4'b0000};
    vecs[19] = '{8'hFF, 16'd2, 4'd1, 8'd11, 4'b0000};
    vecs[20] = '{8'hFF, 16'd2, 4'd1, 8'd12, 4'b1111};

    // Reset state, with nonzero modes held during reset.
    rst = 1'b1; mode = 8'hFF; period = 16'd1; burst_cnt = 4'd2;
    run(3);
    check("reset_outputs", {27'd0, tick_out, led_out}, 32'd0);

    // Tick timing with all channels OFF.
    do_reset(8'h00, 16'd1, 4'd0);
    for (int c = 1; c <= 35; c++) begin
      tick_clk();
      check($sformatf("tick_c%0d", c), {27'd0, tick_out, led_out},
            {27'd0, ((c % DIV) == 0), 4'b0000});
    end

    // Table-driven vectors.
    for (int v = 0; v < NV; v++) begin
      do_reset(vecs[v].mode, vecs[v].period, vecs[v].bcnt);
      run(int'(vecs[v].ticks) * DIV + 1);
      check($sformatf("vec%0d", v), {28'd0, led_out}, {28'd0, vecs[v].exp_led});
    end

    // BLINK period=3: first rise one clock after the 3rd tick, then every 30.
    do_reset(8'h02, 16'd3, 4'd0);
    for (int c = 1; c <= 61; c++) begin
      tick_clk();
      if (c == 30) check("blink_pre_rise", {31'd0, led_out[0]}, 32'd0);
      if (c == 31) check("blink_rise",     {31'd0, led_out[0]}, 32'd1);
      if (c == 60) check("blink_hold",     {31'd0, led_out[0]}, 32'd1);
      if (c == 61) check("blink_fall",     {31'd0, led_out[0]}, 32'd0);
    end

    // Mode change on the tick clock wins over the toggle.
    do_reset(8'h20, 16'd1, 4'd0);
    run(DIV + 1);
    check("swap_blink_high", {31'd0, led_out[2]}, 32'd1);
    seen = 1'b0;
    for (int w = 0; w < DIV + 2; w++) begin
      if (tick_out) begin
        seen = 1'b1;
        break;
      end
      tick_clk();
    end
    check("swap_tick_seen", {31'd0, seen}, 32'd1);
    mode = 8'h10;
    tick_clk();
    check("swap_to_on", {31'd0, led_out[2]}, 32'd1);
    run(25);
    check("swap_on_hold", {31'd0, led_out[2]}, 32'd1);
    mode = 8'h00;
    tick_clk();
    check("swap_to_off", {31'd0, led_out[2]}, 32'd0);

    // Reset in the middle of a burst, on a tick clock.
    do_reset(8'h1C, 16'd1, 4'd3);
    run(2*DIV + 1);
    check("burst_pre_rst", {27'd0, tick_out, led_out}, {27'd0, 1'b0, 4'b0110});
    run(DIV - 1);
    check("burst_tick_rst", {27'd0, tick_out, led_out}, {27'd0, 1'b1, 4'b0110});
    rst = 1'b1;
    tick_clk();
    check("mid_rst_clear", {27'd0, tick_out, led_out}, 32'd0);
    rst = 1'b0;

    // Period shrink mid-phase ends the phase on the next tick.
    do_reset(8'h02, 16'd100, 4'd0);
    run(50*DIV + 1);
    check("shrink_before", {31'd0, led_out[0]}, 32'd0);
    period = 16'd10;
    run(DIV - 1);
    check("shrink_no_early", {31'd0, led_out[0]}, 32'd0);
    run(1);
    check("shrink_toggle", {31'd0, led_out[0]}, 32'd1);
    run(10*DIV - 1);
    check("shrink_hold", {31'd0, led_out[0]}, 32'd1);
    run(1);
    check("shrink_toggle2", {31'd0, led_out[0]}, 32'd0);

    // burst_cnt dropped below the pulses already emitted.
    do_reset(8'h03, 16'd1, 4'd3);
    run(3*DIV + 1);
    check("drop_in_off", {31'd0, led_out[0]}, 32'd0);
    burst_cnt = 4'd1;
    run(DIV);
    check("drop_to_gap", {31'd0, led_out[0]}, 32'd0);
    run(4*DIV);
    check("drop_gap_exit", {31'd0, led_out[0]}, 32'd1);

    // BURST with burst_cnt=0 stays dark for over 100 ticks.
    do_reset(8'h0C, 16'd1, 4'd0);
    lit = 1'b0;
    for (int c = 0; c < 101*DIV; c++) begin
      tick_clk();
      if (led_out[1]) lit = 1'b1;
    end
    check("burst0_dark", {31'd0, lit}, 32'd0);

    // Randomized segments against the tick-count model.
    for (int s = 0; s < 12; s++) begin
      do_reset(8'($urandom), 16'($urandom_range(0, 4)), 4'($urandom_range(0, 3)));
      len = int'($urandom_range(150, 300));
      for (int j = 0; j < len; j++) begin
        tick_clk();
        check($sformatf("rand_s%0d_c%0d", s, j), {27'd0, tick_out, led_out},
              {27'd0, m_tick, m_led});
        if ($urandom_range(0, 19) == 0) begin
          ch = int'($urandom_range(0, NUM_CH - 1));
          mode[2*ch +: 2] = 2'($urandom);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
